avg_window_ctrl: RTL and testbench



---
 rtl/avg_window_ctrl_if.sv | 28 ++
 rtl/avg_window_ctrl.sv | 168 ++++++++++++++++
 tb/tb_avg_window_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/avg_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : avg_window_ctrl_if
// Brief   : Operand/quotient bus between the averaging controller and an
//           external pipelined divider.
// Revision: 1.0 - initial release
// ============================================================================
interface avg_window_ctrl_if #(
    parameter int NUM_W = 64,
    parameter int CNT_W = 32
);
    logic [NUM_W-1:0] div_numer;
    logic [CNT_W-1:0] div_denom;
    logic [NUM_W-1:0] div_quotient;

    modport master (
        output div_numer,
        output div_denom,
        input  div_quotient
    );

    modport slave (
        input  div_numer,
        input  div_denom,
        output div_quotient
    );
endinterface
`default_nettype wire

// File: rtl/avg_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : avg_window_ctrl
// Brief   : Windowed voltage/current averaging on the ADC clock, sharing one
//           pipelined divider. Define AVG_FRAC_EN for 12.4 fixed-point means.
// Revision: 1.0 - initial release
// ============================================================================
module avg_window_ctrl #(
    parameter int SAMPLE_W    = 12,
    parameter int CNT_W       = 32,
    parameter int NUM_W       = 64,
    parameter int DIV_LATENCY = 8,
    parameter int MAX_WINDOW  = 65536
) (
    input  wire logic                ad_clk,
    input  wire logic                rst_n,
    input  wire logic                sample_en,
    input  wire logic [SAMPLE_W-1:0] vol_in,
    input  wire logic [SAMPLE_W-1:0] cur_in,
    input  wire logic                feedback_finish,
    avg_window_ctrl_if.master        div_if,
    output logic [15:0]              avg_vol,
    output logic [15:0]              avg_cur,
    output logic                     avg_valid,
    output logic                     busy,
    output logic                     overrun
);

`ifdef AVG_FRAC_EN
    localparam int c_FRAC_SH = 4;
`else
    localparam int c_FRAC_SH = 0;
`endif

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_ISSUE_V = 3'd1;
    localparam logic [2:0] c_ISSUE_I = 3'd2;
    localparam logic [2:0] c_WAIT    = 3'd3;
    localparam logic [2:0] c_DONE    = 3'd4;

    localparam int              c_LAT_W = $clog2(DIV_LATENCY + 2);
    localparam logic [c_LAT_W-1:0] c_LAT_V = c_LAT_W'(DIV_LATENCY);
    localparam logic [c_LAT_W-1:0] c_LAT_I = c_LAT_W'(DIV_LATENCY + 1);
    localparam logic [CNT_W-1:0]   c_CNT_LAST = CNT_W'(MAX_WINDOW - 1);

    logic [2:0]         r_state;
    logic [NUM_W-1:0]   r_sum_v;
    logic [NUM_W-1:0]   r_sum_i;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_W-1:0]   r_snap_i;
    logic [NUM_W-1:0]   r_div_numer;
    logic [CNT_W-1:0]   r_div_denom;
    logic [c_LAT_W-1:0] r_lat;
    logic [15:0]        r_q_v;
    logic [15:0]        r_avg_vol;
    logic [15:0]        r_avg_cur;
    logic               r_avg_valid;
    logic               r_overrun;

    logic [NUM_W-1:0]   w_sum_v;
    logic [NUM_W-1:0]   w_sum_i;
    logic [CNT_W-1:0]   w_cnt;
    logic               w_close;

    function automatic logic [15:0] f_sat(input logic [NUM_W-1:0] q);
        if (|q[NUM_W-1:16])
            return 16'hFFFF;
        return q[15:0];
    endfunction

    // Sums including the current cycle's sample, used both for accumulation
    // and for the snapshot so a closing-cycle sample is never lost.
    assign w_sum_v = r_sum_v + (sample_en ? NUM_W'(vol_in) : '0);
    assign w_sum_i = r_sum_i + (sample_en ? NUM_W'(cur_in) : '0);
    assign w_cnt   = r_cnt + CNT_W'(sample_en);
    assign w_close = feedback_finish | (sample_en & (r_cnt == c_CNT_LAST));

    always_ff @(posedge ad_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_sum_v     <= '0;
            r_sum_i     <= '0;
            r_cnt       <= '0;
            r_snap_i    <= '0;
            r_div_numer <= '0;
            r_div_denom <= '0;
            r_lat       <= '0;
            r_q_v       <= '0;
            r_avg_vol   <= '0;
            r_avg_cur   <= '0;
            r_avg_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_avg_valid <= 1'b0;

            if (w_close) begin
                r_sum_v <= '0;
                r_sum_i <= '0;
                r_cnt   <= '0;
            end else begin
                r_sum_v <= w_sum_v;
                r_sum_i <= w_sum_i;
                r_cnt   <= w_cnt;
            end

            if (w_close && (r_state != c_IDLE))
                r_overrun <= 1'b1;

            // Quotient timing is counted from the ISSUE_V cycle, so the
            // voltage result may land while still in ISSUE_I.
            if (((r_state == c_ISSUE_I) || (r_state == c_WAIT)) && (r_lat == c_LAT_V))
                r_q_v <= f_sat(div_if.div_quotient);

            case (r_state)
                c_IDLE: begin
                    if (w_close) begin
                        if (w_cnt == '0) begin
                            r_avg_vol   <= '0;
                            r_avg_cur   <= '0;
                            r_avg_valid <= 1'b1;
                            r_state     <= c_DONE;
                        end else begin
                            r_div_numer <= w_sum_v << c_FRAC_SH;
                            r_div_denom <= w_cnt;
                            r_snap_i    <= w_sum_i << c_FRAC_SH;
                            r_lat       <= '0;
                            r_state     <= c_ISSUE_V;
                        end
                    end
                end
                c_ISSUE_V: begin
                    r_div_numer <= r_snap_i;
                    r_lat       <= r_lat + 1'b1;
                    r_state     <= c_ISSUE_I;
                end
                c_ISSUE_I: begin
                    r_lat   <= r_lat + 1'b1;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    r_lat <= r_lat + 1'b1;
                    if (r_lat == c_LAT_I) begin
                        r_avg_vol   <= r_q_v;
                        r_avg_cur   <= f_sat(div_if.div_quotient);
                        r_avg_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign div_if.div_numer = r_div_numer;
    assign div_if.div_denom = r_div_denom;
    assign avg_vol          = r_avg_vol;
    assign avg_cur          = r_avg_cur;
    assign avg_valid        = r_avg_valid;
    assign busy             = (r_state != c_IDLE);
    assign overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_avg_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_avg_window_ctrl
// Brief   : Directed self-checking bench for avg_window_ctrl with a behavioural
//           pipelined divider (MAX_WINDOW shortened to 16).
// Revision: 1.0 - initial release
// ============================================================================
module tb_avg_window_ctrl;

    localparam int L  = 8;
`ifdef AVG_FRAC_EN
    localparam int SH = 4;
`else
    localparam int SH = 0;
`endif

    logic        ad_clk = 1'b0;
    logic        rst_n;
    logic        sample_en;
    logic [11:0] vol_in;
    logic [11:0] cur_in;
    logic        feedback_finish;
    logic [15:0] avg_vol;
    logic [15:0] avg_cur;
    logic        avg_valid;
    logic        busy;
    logic        overrun;
    logic        div_bad;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int nv;

    avg_window_ctrl_if #(.NUM_W(64), .CNT_W(32)) dif ();

    avg_window_ctrl #(
        .SAMPLE_W    (12),
        .CNT_W       (32),
        .NUM_W       (64),
        .DIV_LATENCY (L),
        .MAX_WINDOW  (16)
    ) u_dut (
        .ad_clk          (ad_clk),
        .rst_n           (rst_n),
        .sample_en       (sample_en),
        .vol_in          (vol_in),
        .cur_in          (cur_in),
        .feedback_finish (feedback_finish),
        .div_if          (dif),
        .avg_vol         (avg_vol),
        .avg_cur         (avg_cur),
        .avg_valid       (avg_valid),
        .busy            (busy),
        .overrun         (overrun)
    );

    always #5 ad_clk = ~ad_clk;

    // Divider model: quotient visible L cycles after operands are presented.
    logic [63:0] r_pipe [0:L-1];
    always @(posedge ad_clk) begin
        if (div_bad)
            r_pipe[0] <= 64'h1_0000_0005;
        else if (dif.div_denom != 32'd0)
            r_pipe[0] <= dif.div_numer / {32'd0, dif.div_denom};
        else
            r_pipe[0] <= 64'd0;
        for (int k = 1; k < L; k++)
            r_pipe[k] <= r_pipe[k-1];
    end
    assign dif.div_quotient = r_pipe[L-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ad_clk);
        #1;
    endtask

    task automatic samples(input int n, input int v, input int c);
        vol_in    = 12'(v);
        cur_in    = 12'(c);
        sample_en = 1'b1;
        repeat (n) tick();
        sample_en = 1'b0;
    endtask

    task automatic wait_valid(inout int l);
        while (!avg_valid && l < 40) begin
            tick();
            l++;
        end
    endtask

    // Close in the current cycle (sample_en left as the caller set it) and
    // check the result arrives L+3 cycles later with the given values.
    task automatic close_and_wait(input string tag, input int ev, input int ei);
        int l;
        feedback_finish = 1'b1;
        tick();
        feedback_finish = 1'b0;
        sample_en       = 1'b0;
        l = 1;
        wait_valid(l);
        check({tag, "_valid"}, 64'(avg_valid), 64'd1);
        check({tag, "_lat"},   64'(l),         64'(L + 3));
        check({tag, "_vol"},   64'(avg_vol),   64'(ev));
        check({tag, "_cur"},   64'(avg_cur),   64'(ei));
    endtask

    initial begin
        rst_n = 1'b0; sample_en = 1'b0; vol_in = '0; cur_in = '0;
        feedback_finish = 1'b0; div_bad = 1'b0;
        repeat (3) tick();
        check("rst_vol",   64'(avg_vol),       64'd0);
        check("rst_cur",   64'(avg_cur),       64'd0);
        check("rst_valid", 64'(avg_valid),     64'd0);
        check("rst_busy",  64'(busy),          64'd0);
        check("rst_ovr",   64'(overrun),       64'd0);
        check("rst_numer", dif.div_numer,      64'd0);
        check("rst_denom", 64'(dif.div_denom), 64'd0);
        rst_n = 1'b1;
        tick();

        // 10 x (100, 200), then a close with no sample
        samples(10, 100, 200);
        feedback_finish = 1'b1;
        tick();
        feedback_finish = 1'b0;
        check("t1_busy",   64'(busy),          64'd1);
        check("t1_numv",   dif.div_numer,      64'(1000 << SH));
        check("t1_denom",  64'(dif.div_denom), 64'd10);
        tick();
        check("t1_numi",   dif.div_numer,      64'(2000 << SH));
        lat = 2;
        wait_valid(lat);
        check("t1_lat",    64'(lat),           64'(L + 3));
        check("t1_vol",    64'(avg_vol),       64'(100 << SH));
        check("t1_cur",    64'(avg_cur),       64'(200 << SH));
        tick();
        check("t1_strobe", 64'(avg_valid),     64'd0);
        check("t1_idle",   64'(busy),          64'd0);
        check("t1_hold",   64'(avg_vol),       64'(100 << SH));

        // alternating 0/4095, 4th sample taken in the close cycle
        for (int i = 0; i < 3; i++) begin
            vol_in = (i % 2 == 1) ? 12'd4095 : 12'd0;
            cur_in = 12'd10;
            sample_en = 1'b1;
            tick();
        end
        vol_in = 12'd4095;
        sample_en = 1'b1;
        close_and_wait("t2", (8190 << SH) / 4, 10 << SH);
        check("t2_denom",  64'(dif.div_denom), 64'd4);
        check("t2_numer",  dif.div_numer,      64'(40 << SH));
        tick();

        // empty window
        feedback_finish = 1'b1;
        tick();
        feedback_finish = 1'b0;
        check("t3_valid",  64'(avg_valid),     64'd1);
        check("t3_vol",    64'(avg_vol),       64'd0);
        check("t3_cur",    64'(avg_cur),       64'd0);
        check("t3_numer",  dif.div_numer,      64'(40 << SH));
        check("t3_denom",  64'(dif.div_denom), 64'd4);
        tick();
        check("t3_idle",   64'(busy),          64'd0);

        // oversized quotient saturates
        div_bad = 1'b1;
        samples(2, 1, 1);
        close_and_wait("t4", 16'hFFFF, 16'hFFFF);
        div_bad = 1'b0;
        tick();

        // forced close every 16 samples
        nv = 0;
        vol_in = 12'd7;
        cur_in = 12'd3;
        for (int i = 0; i < 68; i++) begin
            sample_en = (i < 48);
            tick();
            if (avg_valid) begin
                nv++;
                check("t5_vol", 64'(avg_vol), 64'(7 << SH));
                check("t5_cur", 64'(avg_cur), 64'(3 << SH));
            end
        end
        sample_en = 1'b0;
        check("t5_count",  64'(nv),            64'd3);
        check("t5_denom",  64'(dif.div_denom), 64'd16);
        check("t5_ovr",    64'(overrun),       64'd0);

        // close while busy
        samples(5, 50, 60);
        feedback_finish = 1'b1;
        tick();
        feedback_finish = 1'b0;
        tick();
        tick();
        samples(4, 1000, 1000);
        feedback_finish = 1'b1;
        tick();
        feedback_finish = 1'b0;
        lat = 8;
        check("t6_ovr",    64'(overrun),       64'd1);
        check("t6_busy",   64'(busy),          64'd1);
        wait_valid(lat);
        check("t6_lat",    64'(lat),           64'(L + 3));
        check("t6_vol",    64'(avg_vol),       64'(50 << SH));
        check("t6_cur",    64'(avg_cur),       64'(60 << SH));
        check("t6_denom",  64'(dif.div_denom), 64'd5);
        nv = 0;
        repeat (20) begin
            tick();
            if (avg_valid) nv++;
        end
        check("t6_drop",   64'(nv),            64'd0);
        samples(2, 9, 5);
        close_and_wait("t6b", 9 << SH, 5 << SH);
        check("t6_sticky", 64'(overrun),       64'd1);
        tick();

        // reset during WAIT
        samples(4, 20, 8);
        feedback_finish = 1'b1;
        tick();
        feedback_finish = 1'b0;
        repeat (4) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t7_vol",    64'(avg_vol),       64'd0);
        check("t7_cur",    64'(avg_cur),       64'd0);
        check("t7_valid",  64'(avg_valid),     64'd0);
        check("t7_busy",   64'(busy),          64'd0);
        check("t7_ovr",    64'(overrun),       64'd0);
        check("t7_numer",  dif.div_numer,      64'd0);
        #1 rst_n = 1'b1;
        nv = 0;
        repeat (20) begin
            tick();
            if (avg_valid) nv++;
        end
        check("t7_noval",  64'(nv),            64'd0);
        samples(3, 30, 12);
        close_and_wait("t7b", 30 << SH, 12 << SH);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
